mc_control_fsm: RTL

Multicycle control sequencer for the processor datapath. It decodes the instruction register's opcode and funct fields and steps the shared datapath through fetch, decode, execute, memory and write-back phases. Its outputs drive every datapath mux and write enable, including the 2-bit select of the register-file write-address mux. It sits beside the register file, ALU and memory inside the CPU top level.

---
 rtl/mc_control_fsm_if.sv | 43 ++++
 rtl/mc_control_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// mc_control_fsm_if : decode inputs and datapath control bundle for the
//                     multicycle control sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst_sel;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       halted;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
           mem_write, ir_write, reg_write, reg_dst_sel, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, halted, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
           mem_write, ir_write, reg_write, reg_dst_sel, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, halted, illegal
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm : Moore control sequencer stepping the multicycle datapath
//                  through fetch/decode/execute/memory/write-back. Rev 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mc_control_fsm_if.master   bus
);

  localparam logic [3:0] c_MEM_WAIT  = 4'(MEM_WAIT);
  localparam logic [2:0] c_ALU_ADD   = 3'b000;
  localparam logic [2:0] c_ALU_SUB   = 3'b001;
  localparam logic [2:0] c_ALU_AND   = 3'b010;
  localparam logic [2:0] c_ALU_OR    = 3'b011;
  localparam logic [2:0] c_ALU_SLT   = 3'b100;
  localparam logic [5:0] c_OP_RTYPE  = 6'h00;
  localparam logic [5:0] c_OP_J      = 6'h02;
  localparam logic [5:0] c_OP_JAL    = 6'h03;
  localparam logic [5:0] c_OP_BEQ    = 6'h04;
  localparam logic [5:0] c_OP_BNE    = 6'h05;
  localparam logic [5:0] c_OP_ADDI   = 6'h08;
  localparam logic [5:0] c_OP_LUI    = 6'h0f;
  localparam logic [5:0] c_OP_LW     = 6'h23;
  localparam logic [5:0] c_OP_SW     = 6'h2b;
  localparam logic [5:0] c_FN_JR     = 6'h08;
  localparam logic [5:0] c_FN_BREAK  = 6'h0d;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_JR, S_EXEC_I, S_WB_I,
    S_LUI_WB, S_MEM_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM, S_BRANCH, S_JUMP,
    S_JAL, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_illegal;
  logic       w_set_illegal;
  logic       w_cnt_done;
  logic       w_r_valid;
  logic [2:0] w_r_aop;

  assign w_cnt_done = (r_cnt == c_MEM_WAIT);

  // Counter restarts on every state change and saturates at MEM_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RST;
      r_cnt     <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= 4'd0;
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_r_valid = 1'b1;
    w_r_aop   = c_ALU_ADD;
    case (bus.funct)
      6'h20:   w_r_aop = c_ALU_ADD;
      6'h22:   w_r_aop = c_ALU_SUB;
      6'h24:   w_r_aop = c_ALU_AND;
      6'h25:   w_r_aop = c_ALU_OR;
      6'h2a:   w_r_aop = c_ALU_SLT;
      default: w_r_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  if (w_cnt_done) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          c_OP_RTYPE: begin
            if (w_r_valid) begin
              w_next = S_EXEC_R;
            end else if (bus.funct == c_FN_JR) begin
              w_next = S_JR;
            end else if (bus.funct == c_FN_BREAK) begin
              w_next = S_HALT;
            end else begin
              w_next        = S_HALT;
              w_set_illegal = 1'b1;
            end
          end
          c_OP_ADDI:          w_next = S_EXEC_I;
          c_OP_LUI:           w_next = S_LUI_WB;
          c_OP_LW, c_OP_SW:   w_next = S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:             w_next = S_JUMP;
          c_OP_JAL:           w_next = S_JAL;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (bus.opcode == c_OP_LW) ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM:   if (w_cnt_done) w_next = S_LW_WB;
      S_SW_MEM:   if (w_cnt_done) w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_src        = 2'b00;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst_sel   = 2'b00;
    bus.mem_to_reg    = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = c_ALU_ADD;
    bus.halted        = (r_state == S_HALT);
    bus.illegal       = r_illegal;
    case (r_state)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (w_cnt_done) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_b = 2'b01;
        end
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = w_r_aop;
      end
      S_WB_R: begin
        bus.reg_write   = 1'b1;
        bus.reg_dst_sel = 2'b01;
      end
      S_JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b11;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_WB_I:   bus.reg_write = 1'b1;
      S_LUI_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b11;
      end
      S_LW_MEM: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_LW_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      S_SW_MEM: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = c_ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        bus.branch_ne     = (bus.opcode == c_OP_BNE);
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
      end
      // Register file samples the pre-edge PC, so both writes share one edge.
      S_JAL: begin
        bus.pc_write    = 1'b1;
        bus.pc_src      = 2'b10;
        bus.reg_write   = 1'b1;
        bus.reg_dst_sel = 2'b11;
        bus.mem_to_reg  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
